// File: rtl/strobe_debounce.sv
// -----------------------------------------------------------------------------
// strobe_debounce
//   Debounces one raw push-button for the game controller.
//
//   The raw input passes through a two-flop synchroniser that runs on every
//   clock. The debounce FSM looks only at the synchronised sample, and only
//   on cycles where the divider's slow-enable strobe is high. The level
//   changes after STABLE_TICKS consecutive equal qualified samples. A debounced
//   0->1 transition produces a one-clock press pulse. It also raises an event
//   flag that stays up until the consumer acknowledges it.
//
//   Optional feature (macro STROBE_DEBOUNCE_RELEASE_EN):
//     When the macro is defined, a debounced 1->0 transition also raises
//     evt_valid. evt_is_release tells the consumer which kind of event was
//     latched: 1 = release, 0 = press.
//
// Parameters
//   STABLE_TICKS  consecutive equal qualified samples needed to change level (1..15)
//   CNT_W         tick counter width; must hold STABLE_TICKS
//
// Ports
//   clk            system clock, single domain
//   rst            synchronous active-high reset
//   slowen         one-clock strobe from the divider; qualifies FSM samples
//   btn_raw        asynchronous raw button, active-high
//   btn_level      debounced button level
//   press          one-clock pulse on a debounced 0->1 transition
//   evt_valid      event pending, held until acknowledged
//   evt_ack        consumer accepts the pending event
//   overrun        sticky: an event arrived while the previous one was unaccepted
//   evt_is_release (STROBE_DEBOUNCE_RELEASE_EN only) kind of the latched event
// -----------------------------------------------------------------------------
module strobe_debounce #(
  parameter int STABLE_TICKS = 4,
  parameter int CNT_W        = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic slowen,
  input  logic btn_raw,
  output logic btn_level,
  output logic press,
  output logic evt_valid,
  input  logic evt_ack,
  output logic overrun
`ifdef STROBE_DEBOUNCE_RELEASE_EN
  ,
  output logic evt_is_release
`endif
);

  typedef enum logic [1:0] {
    ST_UP      = 2'd0,
    ST_CONF_DN = 2'd1,
    ST_DN      = 2'd2,
    ST_CONF_UP = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] TICKS_C = CNT_W'(STABLE_TICKS);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO_C  = CNT_W'(0);

`ifdef STROBE_DEBOUNCE_RELEASE_EN
  localparam logic RELEASE_EN_C = 1'b1;
`else
  localparam logic RELEASE_EN_C = 1'b0;
`endif

  logic             s1_r;
  logic             s2_r;
  state_t           state_r;
  state_t           state_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             level_r;
  logic             level_next_s;
  logic             press_adv_s;
  logic             rel_adv_s;
  logic             press_set_s;
  logic             release_set_s;
  logic             evt_set_s;
  logic             press_r;
  logic             evt_valid_r;
  logic             evt_valid_next_s;
  logic             overrun_r;
  logic             overrun_next_s;

  assign cnt_inc_s     = cnt_r + ONE_C;
  // The advance flags describe what the FSM would do on a strobe. They count as real events only when slowen qualifies the edge.
  assign press_set_s   = slowen & press_adv_s;
  assign release_set_s = slowen & rel_adv_s;
  assign evt_set_s     = press_set_s | (RELEASE_EN_C & release_set_s);

  // Two-flop synchroniser for the asynchronous button. It runs on every clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
    end else begin
      s1_r <= btn_raw;
      s2_r <= s2_r == s1_r ? s1_r : s1_r;
    end
  end

  // Debounce state, counter and level. These advance only on qualified strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_UP;
      cnt_r   <= ZERO_C;
      level_r <= 1'b0;
    end else if (slowen) begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      level_r <= level_next_s;
    end else begin
      state_r <= state_r;
      cnt_r   <= cnt_r;
      level_r <= level_r;
    end
  end

  // Next-state logic of the debounce FSM. A single-tick configuration skips the confirm states.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    level_next_s = level_r;
    press_adv_s  = 1'b0;
    rel_adv_s    = 1'b0;
    case (state_r)
      ST_UP: begin
        if (s2_r) begin
          if (STABLE_TICKS == 1) begin
            state_next_s = ST_DN;
            level_next_s = 1'b1;
            press_adv_s  = 1'b1;
            cnt_next_s   = ZERO_C;
          end else begin
            state_next_s = ST_CONF_DN;
            cnt_next_s   = ONE_C;
          end
        end else begin
          cnt_next_s = ZERO_C;
        end
      end
      ST_CONF_DN: begin
        if (s2_r) begin
          if (cnt_inc_s == TICKS_C) begin
            state_next_s = ST_DN;
            level_next_s = 1'b1;
            press_adv_s  = 1'b1;
            cnt_next_s   = ZERO_C;
          end else begin
            cnt_next_s = cnt_inc_s;
          end
        end else begin
          state_next_s = ST_UP;
          cnt_next_s   = ZERO_C;
        end
      end
      ST_DN: begin
        if (!s2_r) begin
          if (STABLE_TICKS == 1) begin
            state_next_s = ST_UP;
            level_next_s = 1'b0;
            rel_adv_s    = 1'b1;
            cnt_next_s   = ZERO_C;
          end else begin
            state_next_s = ST_CONF_UP;
            cnt_next_s   = ONE_C;
          end
        end else begin
          cnt_next_s = ZERO_C;
        end
      end
      ST_CONF_UP: begin
        if (!s2_r) begin
          if (cnt_inc_s == TICKS_C) begin
            state_next_s = ST_UP;
            level_next_s = 1'b0;
            rel_adv_s    = 1'b1;
            cnt_next_s   = ZERO_C;
          end else begin
            cnt_next_s = cnt_inc_s;
          end
        end else begin
          state_next_s = ST_DN;
          cnt_next_s   = ZERO_C;
        end
      end
      default: begin
        state_next_s = ST_UP;
        cnt_next_s   = ZERO_C;
        level_next_s = 1'b0;
      end
    endcase
  end

  // Event handshake. A new event wins over a simultaneous ack. An event arriving while one is unaccepted and not being acked sets the sticky overrun flag.
  always_comb begin
    evt_valid_next_s = evt_valid_r;
    overrun_next_s   = overrun_r;
    if (evt_set_s) begin
      evt_valid_next_s = 1'b1;
      if (evt_valid_r && !evt_ack) begin
        overrun_next_s = 1'b1;
      end else begin
        overrun_next_s = overrun_r;
      end
    end else if (evt_ack) begin
      evt_valid_next_s = 1'b0;
    end else begin
      evt_valid_next_s = evt_valid_r;
    end
  end

  // Press pulse and handshake registers. These run every clock, so the pulse always drops after one cycle and an ack is never delayed to a strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      press_r     <= 1'b0;
      evt_valid_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      press_r     <= press_set_s;
      evt_valid_r <= evt_valid_next_s;
      overrun_r   <= overrun_next_s;
    end
  end

`ifdef STROBE_DEBOUNCE_RELEASE_EN
  logic evt_is_release_r;

  // Event kind. It is latched whenever an event raises evt_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      evt_is_release_r <= 1'b0;
    end else if (evt_set_s) begin
      evt_is_release_r <= release_set_s;
    end else begin
      evt_is_release_r <= evt_is_release_r;
    end
  end

  assign evt_is_release = evt_is_release_r;
`endif

  assign btn_level = level_r;
  assign press     = press_r;
  assign evt_valid = evt_valid_r;
  assign overrun   = overrun_r;

endmodule

// File: tb/tb_strobe_debounce.sv
// -----------------------------------------------------------------------------
// tb_strobe_debounce
//   Self-checking bench for strobe_debounce with STABLE_TICKS=4.
//   A behavioural reference model, written as a run-length counter, computes
//   the expected outputs at every clock edge and pushes them to a queue. A
//   monitor on the falling edge pops each entry and compares it with the DUT.
//   Directed checks cover the listed scenarios.
//   Define STROBE_DEBOUNCE_RELEASE_EN to build and check the release-event variant.
// -----------------------------------------------------------------------------
module tb_strobe_debounce;

  localparam int TICKS = 4;
`ifdef STROBE_DEBOUNCE_RELEASE_EN
  localparam bit REL_EN = 1'b1;
`else
  localparam bit REL_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  logic slowen;
  logic btn_raw;
  logic btn_level;
  logic press;
  logic evt_valid;
  logic evt_ack;
  logic overrun;
  logic evt_is_release;

  strobe_debounce #(.STABLE_TICKS(TICKS), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .slowen    (slowen),
    .btn_raw   (btn_raw),
    .btn_level (btn_level),
    .press     (press),
    .evt_valid (evt_valid),
    .evt_ack   (evt_ack),
    .overrun   (overrun)
`ifdef STROBE_DEBOUNCE_RELEASE_EN
    ,
    .evt_is_release (evt_is_release)
`endif
  );

`ifndef STROBE_DEBOUNCE_RELEASE_EN
  assign evt_is_release = 1'b0;
`endif

  typedef struct packed {
    logic level;
    logic press;
    logic valid;
    logic ovr;
    logic rel;
  } exp_t;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  int   press_cnt = 0;

  // Reference model state
  logic m_s1, m_s2, m_level, m_press, m_valid, m_ovr, m_rel;
  int   m_run;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: counts consecutive qualified samples that disagree with the level
  always @(posedge clk) begin
    bit ev_p, ev_r, ev;
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_level = 0; m_run = 0;
      m_press = 0; m_valid = 0; m_ovr = 0; m_rel = 0;
    end else begin
      ev_p = 0; ev_r = 0;
      if (slowen) begin
        if (m_s2 != m_level) begin
          m_run++;
          if (m_run == TICKS) begin
            m_level = !m_level;
            m_run = 0;
            if (m_level) ev_p = 1; else ev_r = 1;
          end
        end else begin
          m_run = 0;
        end
      end
      ev = ev_p || (REL_EN && ev_r);
      if (ev) begin
        if (m_valid && !evt_ack) m_ovr = 1;
        m_valid = 1;
        m_rel = ev_r;
      end else if (evt_ack) begin
        m_valid = 0;
      end
      m_press = ev_p;
      m_s2 = m_s1;
      m_s1 = btn_raw;
    end
    q.push_back('{level: m_level, press: m_press, valid: m_valid, ovr: m_ovr, rel: m_rel});
  end

  // Scoreboard: compare each clock's expected outputs away from the active edge
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("sb_level", int'(btn_level), int'(e.level));
      check("sb_press", int'(press), int'(e.press));
      check("sb_valid", int'(evt_valid), int'(e.valid));
      check("sb_overrun", int'(overrun), int'(e.ovr));
      if (REL_EN) check("sb_is_release", int'(evt_is_release), int'(e.rel));
    end
    if (press) press_cnt++;
  end

  task automatic step(input logic sl);
    slowen = sl;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0);
  endtask

  task automatic strobes(input int n, input int period);
    repeat (n) begin
      repeat (period - 1) step(1'b0);
      step(1'b1);
    end
    slowen = 1'b0;
  endtask

  task automatic ack_pulse();
    evt_ack = 1'b1;
    step(1'b0);
    evt_ack = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) step(1'b0);
    rst = 1'b0;
  endtask

  initial begin
    int base;
    rst = 1'b1; slowen = 1'b0; btn_raw = 1'b0; evt_ack = 1'b0;
    @(negedge clk);

    // 1: reset with the button toggling and strobes present
    for (int i = 0; i < 3; i++) begin
      btn_raw = ~btn_raw;
      step(1'b1);
    end
    check("t1_level", int'(btn_level), 0);
    check("t1_press", int'(press), 0);
    check("t1_valid", int'(evt_valid), 0);
    check("t1_overrun", int'(overrun), 0);
    rst = 1'b0; btn_raw = 1'b0;
    idle(4);

    // 2: slow strobe every 256th clock, button held high
    base = press_cnt;
    btn_raw = 1'b1;
    strobes(3, 256);
    check("t2_no_early_press", press_cnt - base, 0);
    strobes(1, 256);
    check("t2_press_high", int'(press), 1);
    step(1'b0);
    check("t2_press_low", int'(press), 0);
    idle(300);
    check("t2_one_press", press_cnt - base, 1);
    check("t2_level", int'(btn_level), 1);
    check("t2_valid", int'(evt_valid), 1);
    ack_pulse();
    check("t2_ack_clears", int'(evt_valid), 0);
    btn_raw = 1'b0;
    strobes(4, 8);
    idle(2);
    check("t2_release_level", int'(btn_level), 0);
    if (REL_EN) ack_pulse();

    // 3: bounce (2 high, 1 low) then 4 high yields exactly one late press
    base = press_cnt;
    btn_raw = 1'b1; strobes(2, 8);
    btn_raw = 1'b0; strobes(1, 8);
    btn_raw = 1'b1; strobes(3, 8);
    idle(3);
    check("t3_no_press_yet", press_cnt - base, 0);
    strobes(1, 8);
    idle(3);
    check("t3_one_press", press_cnt - base, 1);

    // 4: second press while the first is still pending sets sticky overrun
    btn_raw = 1'b0; strobes(4, 8);
    btn_raw = 1'b1; strobes(4, 8);
    idle(3);
    check("t4_overrun", int'(overrun), 1);
    check("t4_valid", int'(evt_valid), 1);
    ack_pulse();
    check("t4_valid_acked", int'(evt_valid), 0);
    idle(5);
    check("t4_overrun_sticky", int'(overrun), 1);

    // 5: ack on the same edge as a new press
    do_reset(3);
    check("t5_reset_overrun", int'(overrun), 0);
    btn_raw = 1'b1; strobes(4, 8);
    btn_raw = 1'b0; strobes(4, 8);
    if (REL_EN) ack_pulse();
    btn_raw = 1'b1; strobes(3, 8);
    idle(7);
    evt_ack = 1'b1;
    step(1'b1);
    evt_ack = 1'b0;
    slowen = 1'b0;
    check("t5_press", int'(press), 1);
    check("t5_valid_kept", int'(evt_valid), 1);
    check("t5_no_overrun", int'(overrun), 0);
    ack_pulse();
    check("t5_next_ack", int'(evt_valid), 0);

    // Boundary: continuously high slowen gives a per-clock debounce; a held button presses once
    base = press_cnt;
    btn_raw = 1'b0;
    repeat (10) step(1'b1);
    check("cont_release", int'(btn_level), 0);
    btn_raw = 1'b1;
    repeat (30) step(1'b1);
    slowen = 1'b0;
    check("cont_level", int'(btn_level), 1);
    check("cont_one_press", press_cnt - base, 1);
    ack_pulse();

    // Boundary: reset in the middle of a confirmation
    btn_raw = 1'b0; strobes(2, 8);
    rst = 1'b1; step(1'b1); rst = 1'b0;
    check("midrst_level", int'(btn_level), 0);
    check("midrst_valid", int'(evt_valid), 0);
    check("midrst_press", int'(press), 0);
    idle(4);

    // Random noise: the scoreboard checks every cycle
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(5) == 0) btn_raw = ~btn_raw;
      evt_ack = ($urandom_range(7) == 0);
      step($urandom_range(2) == 0);
    end
    evt_ack = 1'b0;
    idle(4);

`ifdef STROBE_DEBOUNCE_RELEASE_EN
    // 6: release event
    do_reset(2);
    btn_raw = 1'b1; strobes(4, 8);
    idle(2);
    ack_pulse();
    btn_raw = 1'b0; strobes(4, 8);
    idle(2);
    check("t6_valid", int'(evt_valid), 1);
    check("t6_is_release", int'(evt_is_release), 1);
    check("t6_level", int'(btn_level), 0);
`endif

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
